// File: rtl/mipi_csi_pkg.sv
// Shared constants, FSM encoding and header ECC function for the CSI-2 packet path.
package mipi_csi_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'hB8;
  localparam logic [5:0] DT_FS       = 6'h00;
  localparam logic [5:0] DT_FE       = 6'h01;
  localparam logic [5:0] DT_LONG_MIN = 6'h10;
  localparam logic [5:0] DT_RAW6     = 6'h28;
  localparam logic [5:0] DT_RAW7     = 6'h29;
  localparam logic [5:0] DT_RAW8     = 6'h2A;
  localparam logic [5:0] DT_RAW10    = 6'h2B;
  localparam logic [5:0] DT_RAW12    = 6'h2C;
  localparam logic [5:0] DT_RAW14    = 6'h2D;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_SKIP
  } state_t;

  // CSI-2 Hamming parity over {WC_H, WC_L, DI}; d[0] is DI[0].
  function automatic logic [5:0] csi_header_ecc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[10] ^ d[11] ^ d[13] ^ d[16]
         ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    p[1] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10] ^ d[12] ^ d[14] ^ d[17]
         ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    p[2] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[11] ^ d[12] ^ d[15] ^ d[18]
         ^ d[20] ^ d[21] ^ d[22];
    p[3] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[13] ^ d[14] ^ d[15] ^ d[19]
         ^ d[20] ^ d[21] ^ d[23];
    p[4] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[16] ^ d[17] ^ d[18] ^ d[19]
         ^ d[20] ^ d[22] ^ d[23];
    p[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^ d[17] ^ d[18] ^ d[19]
         ^ d[21] ^ d[22] ^ d[23];
    return p;
  endfunction

endpackage

// File: rtl/mipi_csi_header_ecc.sv
// Combinational header ECC generator and comparator; shared with the TX packer.
module mipi_csi_header_ecc
  import mipi_csi_pkg::*;
(
  input  logic [23:0] header,
  input  logic [5:0]  ecc,
  output logic        ecc_ok
);

  assign ecc_ok = (csi_header_ecc(header) == ecc);

endmodule

// File: rtl/mipi_csi_packet_decoder_ml.sv
// CSI-2 packet decoder: sync search, header ECC check, DT/VC filtering and payload extraction.
module mipi_csi_packet_decoder_ml
  import mipi_csi_pkg::*;
#(
  parameter int unsigned LANES         = 4,
  parameter logic [7:0]  RAW_TYPE_MASK = 8'b0011_1000,
  parameter logic [3:0]  VC_MASK       = 4'hF
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 data_valid_i,
  input  logic [8*LANES-1:0]   data_i,
  output logic                 output_valid_o,
  output logic [8*LANES-1:0]   data_o,
  output logic [LANES-1:0]     byte_en_o,
  output logic                 last_o,
  output logic [15:0]          packet_length_o,
  output logic [5:0]           packet_type_o,
  output logic [1:0]           virtual_channel_o,
  output logic                 frame_start_o,
  output logic                 frame_end_o,
  output logic                 ecc_error_o
);

  localparam int unsigned DW        = 8 * LANES;
  localparam int unsigned HDR_BEATS = 4 / LANES;

  state_t            state_q, state_d;
  logic              in_valid_q;
  logic [DW-1:0]     in_data_q;
  logic [29:0]       hdr_buf_q, hdr_buf_d, hdr_full;
  logic [1:0]        hdr_cnt_q, hdr_cnt_d;
  logic [15:0]       remaining_q, remaining_d;

  logic              valid_d, last_d, fs_d, fe_d, ecc_err_d;
  logic [DW-1:0]     data_d;
  logic [LANES-1:0]  be_d, be_part;
  logic [15:0]       len_d, step;
  logic [5:0]        type_d, dt;
  logic [1:0]        vc_d, vc;
  logic [15:0]       wc;
  logic              ecc_ok, hdr_last, sync_seen, type_ok, vc_ok, full_beat, final_beat;

  // Header bytes accumulate lane 0 first; the last beat is merged combinationally.
  assign hdr_full   = hdr_buf_q | 30'(32'(in_data_q) << (32'(hdr_cnt_q) * DW));
  assign dt         = hdr_full[5:0];
  assign vc         = hdr_full[7:6];
  assign wc         = hdr_full[23:8];
  assign hdr_last   = (hdr_cnt_q == 2'(HDR_BEATS - 1));
  assign sync_seen  = in_valid_q && (in_data_q[7:0] == SYNC_BYTE);
  assign vc_ok      = VC_MASK[vc];
  assign type_ok    = (dt >= DT_RAW6) && (dt <= DT_RAW6 + 6'd7)
                      && RAW_TYPE_MASK[3'(dt - DT_RAW6)];

  assign full_beat  = (remaining_q >= 16'(LANES));
  assign final_beat = (remaining_q <= 16'(LANES));
  assign step       = full_beat ? 16'(LANES) : remaining_q;
  assign be_part    = LANES'((4'd1 << remaining_q[1:0]) - 4'd1);

  mipi_csi_header_ecc u_header_ecc (
    .header (hdr_full[23:0]),
    .ecc    (hdr_full[29:24]),
    .ecc_ok (ecc_ok)
  );

  always_comb begin
    state_d     = state_q;
    hdr_buf_d   = hdr_buf_q;
    hdr_cnt_d   = hdr_cnt_q;
    remaining_d = remaining_q;
    valid_d     = 1'b0;
    data_d      = '0;
    be_d        = '0;
    last_d      = 1'b0;
    len_d       = packet_length_o;
    type_d      = packet_type_o;
    vc_d        = virtual_channel_o;
    fs_d        = 1'b0;
    fe_d        = 1'b0;
    ecc_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (sync_seen) begin
          state_d   = ST_HDR;
          hdr_buf_d = '0;
          hdr_cnt_d = '0;
        end
      end

      ST_HDR: begin
        if (!in_valid_q) begin
          state_d = ST_IDLE;
        end else if (!hdr_last) begin
          hdr_buf_d = hdr_full;
          hdr_cnt_d = 2'(hdr_cnt_q + 2'd1);
        end else if (!ecc_ok) begin
          ecc_err_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (dt < DT_LONG_MIN) begin
          state_d = ST_IDLE;
          fs_d    = vc_ok && (dt == DT_FS);
          fe_d    = vc_ok && (dt == DT_FE);
        end else begin
          remaining_d = wc;
          if (type_ok && vc_ok) begin
            len_d   = wc;
            type_d  = dt;
            vc_d    = vc;
            state_d = (wc == 16'd0) ? ST_IDLE : ST_PAYLOAD;
          end else begin
            state_d = (wc == 16'd0) ? ST_IDLE : ST_SKIP;
          end
        end
      end

      ST_PAYLOAD: begin
        if (!in_valid_q) begin
          state_d = ST_IDLE;
        end else begin
          valid_d     = 1'b1;
          data_d      = in_data_q;
          be_d        = full_beat ? '1 : be_part;
          last_d      = final_beat;
          remaining_d = remaining_q - step;
          if (final_beat) state_d = ST_IDLE;
        end
      end

      // Rejected packets are counted through so payload bytes never look like sync.
      ST_SKIP: begin
        if (!in_valid_q) begin
          state_d = ST_IDLE;
        end else begin
          remaining_d = remaining_q - step;
          if (final_beat) state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(negedge clk_i) begin
    if (!reset_n_i) begin
      state_q           <= ST_IDLE;
      in_valid_q        <= 1'b0;
      in_data_q         <= '0;
      hdr_buf_q         <= '0;
      hdr_cnt_q         <= '0;
      remaining_q       <= '0;
      output_valid_o    <= 1'b0;
      data_o            <= '0;
      byte_en_o         <= '0;
      last_o            <= 1'b0;
      packet_length_o   <= '0;
      packet_type_o     <= '0;
      virtual_channel_o <= '0;
      frame_start_o     <= 1'b0;
      frame_end_o       <= 1'b0;
      ecc_error_o       <= 1'b0;
    end else begin
      state_q           <= state_d;
      in_valid_q        <= data_valid_i;
      in_data_q         <= data_i;
      hdr_buf_q         <= hdr_buf_d;
      hdr_cnt_q         <= hdr_cnt_d;
      remaining_q       <= remaining_d;
      output_valid_o    <= valid_d;
      data_o            <= data_d;
      byte_en_o         <= be_d;
      last_o            <= last_d;
      packet_length_o   <= len_d;
      packet_type_o     <= type_d;
      virtual_channel_o <= vc_d;
      frame_start_o     <= fs_d;
      frame_end_o       <= fe_d;
      ecc_error_o       <= ecc_err_d;
    end
  end

endmodule

// File: tb/tb_mipi_csi_packet_decoder_ml.sv
// Directed bench for the CSI-2 packet decoder: 4-lane and 2-lane instances.
module tb_mipi_csi_packet_decoder_ml;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  be;
    logic        last;
    time         t;
  } beat_t;

  logic clk, rst_n;
  logic dv4, dv2;
  logic [31:0] d4;
  logic [15:0] d2;

  logic ov4, last4, fs4, fe4, ecc4;
  logic [31:0] do4;
  logic [3:0]  be4;
  logic [15:0] len4;
  logic [5:0]  type4;
  logic [1:0]  vc4;

  logic ov2, last2, fs2, fe2, ecc2;
  logic [15:0] do2;
  logic [1:0]  be2;
  logic [15:0] len2;
  logic [5:0]  type2;
  logic [1:0]  vc2;

  beat_t q4[$];
  beat_t q2[$];
  int fs4_n, fe4_n, ecc4_n, fs2_n, fe2_n, ecc2_n;
  int n_cmp, n_bad;
  time t0;

  mipi_csi_packet_decoder_ml #(.LANES(4)) dut4 (
    .clk_i(clk), .reset_n_i(rst_n), .data_valid_i(dv4), .data_i(d4),
    .output_valid_o(ov4), .data_o(do4), .byte_en_o(be4), .last_o(last4),
    .packet_length_o(len4), .packet_type_o(type4), .virtual_channel_o(vc4),
    .frame_start_o(fs4), .frame_end_o(fe4), .ecc_error_o(ecc4)
  );

  mipi_csi_packet_decoder_ml #(.LANES(2)) dut2 (
    .clk_i(clk), .reset_n_i(rst_n), .data_valid_i(dv2), .data_i(d2),
    .output_valid_o(ov2), .data_o(do2), .byte_en_o(be2), .last_o(last2),
    .packet_length_o(len2), .packet_type_o(type2), .virtual_channel_o(vc2),
    .frame_start_o(fs2), .frame_end_o(fe2), .ecc_error_o(ecc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT updates on the falling edge; observe on the rising edge.
  always @(posedge clk) begin
    if (ov4) q4.push_back('{do4, be4, last4, $time});
    if (ov2) q2.push_back('{32'(do2), 4'(be2), last2, $time});
    fs4_n  += int'(fs4);
    fe4_n  += int'(fe4);
    ecc4_n += int'(ecc4);
    fs2_n  += int'(fs2);
    fe2_n  += int'(fe2);
    ecc2_n += int'(ecc2);
  end

  task automatic beat4(input logic v, input logic [31:0] d);
    @(posedge clk);
    dv4 = v;
    d4  = d;
  endtask

  task automatic beat2(input logic v, input logic [15:0] d);
    @(posedge clk);
    dv2 = v;
    d2  = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      dv4 = 1'b0; d4 = '0;
      dv2 = 1'b0; d2 = '0;
    end
  endtask

  task automatic clear_logs();
    q4.delete();
    q2.delete();
    fs4_n = 0; fe4_n = 0; ecc4_n = 0;
    fs2_n = 0; fe2_n = 0; ecc2_n = 0;
  endtask

  // RAW10, WC=8, ECC 0x32, two payload beats then CRC.
  task automatic send_wc8();
    beat4(1'b1, 32'hB8B8_B8B8);
    beat4(1'b1, 32'h3200_082B);
    beat4(1'b1, 32'h4433_2211);
    beat4(1'b1, 32'h8877_6655);
    beat4(1'b1, 32'h0000_A5A5);
    idle(4);
  endtask

  // RAW10, WC=10, ECC 0x2E, last payload beat carries two bytes.
  task automatic send_wc10();
    beat4(1'b1, 32'hB8B8_B8B8);
    beat4(1'b1, 32'h2E00_0A2B);
    beat4(1'b1, 32'hA4A3_A2A1);
    beat4(1'b1, 32'hB4B3_B2B1);
    beat4(1'b1, 32'h0000_C2C1);
    beat4(1'b1, 32'h0000_5A5A);
    idle(4);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    n_cmp += 6;
    if (ov4 !== 1'b0)       begin n_bad++; $display("FAIL reset_valid got %b exp 0", ov4); end
    if (do4 !== 32'h0)      begin n_bad++; $display("FAIL reset_data got %h exp 0", do4); end
    if (be4 !== 4'h0)       begin n_bad++; $display("FAIL reset_be got %h exp 0", be4); end
    if ({last4, fs4, fe4, ecc4} !== 4'h0) begin n_bad++; $display("FAIL reset_flags got %b exp 0000", {last4, fs4, fe4, ecc4}); end
    if ({len4, type4, vc4} !== 24'h0) begin n_bad++; $display("FAIL reset_meta got %h exp 0", {len4, type4, vc4}); end
    if ({ov2, len2} !== 17'h0) begin n_bad++; $display("FAIL reset_lanes2 got %h exp 0", {ov2, len2}); end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    clear_logs();
    beat4(1'b1, 32'hB8B8_B8B8);
    beat4(1'b1, 32'h3200_082B);
    beat4(1'b1, 32'h4433_2211);
    t0 = $time;
    beat4(1'b1, 32'h8877_6655);
    beat4(1'b1, 32'h0000_A5A5);
    idle(4);
    n_cmp++;
    if (q4.size() !== 2) begin n_bad++; $display("FAIL basic_count got %0d exp 2", q4.size()); end
    if (q4.size() >= 2) begin
      n_cmp += 5;
      if (q4[0].data !== 32'h4433_2211 || q4[1].data !== 32'h8877_6655) begin n_bad++; $display("FAIL basic_data got %h %h exp 44332211 88776655", q4[0].data, q4[1].data); end
      if (q4[0].be !== 4'hF || q4[1].be !== 4'hF) begin n_bad++; $display("FAIL basic_be got %h %h exp f f", q4[0].be, q4[1].be); end
      if (q4[0].last !== 1'b0) begin n_bad++; $display("FAIL basic_last0 got %b exp 0", q4[0].last); end
      if (q4[1].last !== 1'b1) begin n_bad++; $display("FAIL basic_last1 got %b exp 1", q4[1].last); end
      if (q4[0].t - t0 !== time'(20)) begin n_bad++; $display("FAIL basic_latency got %0t exp 20", q4[0].t - t0); end
    end
    n_cmp += 3;
    if (len4 !== 16'd8)  begin n_bad++; $display("FAIL basic_len got %0d exp 8", len4); end
    if (type4 !== 6'h2B) begin n_bad++; $display("FAIL basic_type got %h exp 2b", type4); end
    if (vc4 !== 2'd0 || ecc4_n !== 0) begin n_bad++; $display("FAIL basic_vc_ecc got vc %0d ecc %0d exp 0 0", vc4, ecc4_n); end
  endtask

  task automatic test_partial_beat();
    clear_logs();
    send_wc10();
    n_cmp++;
    if (q4.size() !== 3) begin n_bad++; $display("FAIL partial_count got %0d exp 3", q4.size()); end
    if (q4.size() >= 3) begin
      n_cmp += 3;
      if ({q4[0].be, q4[1].be, q4[2].be} !== 12'hFF3) begin n_bad++; $display("FAIL partial_be got %h exp ff3", {q4[0].be, q4[1].be, q4[2].be}); end
      if ({q4[0].last, q4[1].last, q4[2].last} !== 3'b001) begin n_bad++; $display("FAIL partial_last got %b exp 001", {q4[0].last, q4[1].last, q4[2].last}); end
      if (q4[2].data !== 32'h0000_C2C1) begin n_bad++; $display("FAIL partial_data got %h exp 0000c2c1", q4[2].data); end
    end
    n_cmp++;
    if (len4 !== 16'd10) begin n_bad++; $display("FAIL partial_len got %0d exp 10", len4); end
  endtask

  task automatic test_short_lanes2();
    clear_logs();
    beat2(1'b1, 16'hB8B8);
    beat2(1'b1, 16'h0000);
    beat2(1'b1, 16'h0000);
    idle(4);
    n_cmp += 2;
    if (fs2_n !== 1) begin n_bad++; $display("FAIL fs_pulse got %0d exp 1", fs2_n); end
    if (fe2_n !== 0) begin n_bad++; $display("FAIL fs_no_fe got %0d exp 0", fe2_n); end
    beat2(1'b1, 16'hB8B8);
    beat2(1'b1, 16'h0001);
    beat2(1'b1, 16'h0700);
    idle(4);
    n_cmp += 3;
    if (fe2_n !== 1 || fs2_n !== 1) begin n_bad++; $display("FAIL fe_pulse got fe %0d fs %0d exp 1 1", fe2_n, fs2_n); end
    if (q2.size() !== 0) begin n_bad++; $display("FAIL short_no_payload got %0d exp 0", q2.size()); end
    if (ecc2_n !== 0) begin n_bad++; $display("FAIL short_ecc got %0d exp 0", ecc2_n); end
  endtask

  task automatic test_odd_lanes2();
    clear_logs();
    beat2(1'b1, 16'hB8B8);
    beat2(1'b1, 16'h052B);
    beat2(1'b1, 16'h2E00);
    beat2(1'b1, 16'h2211);
    beat2(1'b1, 16'h4433);
    beat2(1'b1, 16'hC055);
    beat2(1'b1, 16'hC1C1);
    idle(4);
    n_cmp++;
    if (q2.size() !== 3) begin n_bad++; $display("FAIL odd_count got %0d exp 3", q2.size()); end
    if (q2.size() >= 3) begin
      n_cmp += 3;
      if ({q2[0].be, q2[1].be, q2[2].be} !== 12'h331) begin n_bad++; $display("FAIL odd_be got %h exp 331", {q2[0].be, q2[1].be, q2[2].be}); end
      if ({q2[0].last, q2[1].last, q2[2].last} !== 3'b001) begin n_bad++; $display("FAIL odd_last got %b exp 001", {q2[0].last, q2[1].last, q2[2].last}); end
      if (q2[1].data !== 32'h0000_4433) begin n_bad++; $display("FAIL odd_data got %h exp 00004433", q2[1].data); end
    end
    n_cmp++;
    if (len2 !== 16'd5 || type2 !== 6'h2B) begin n_bad++; $display("FAIL odd_meta got len %0d type %h exp 5 2b", len2, type2); end
  endtask

  task automatic test_ecc_error();
    clear_logs();
    beat4(1'b1, 32'hB8B8_B8B8);
    beat4(1'b1, 32'h3300_082B);
    beat4(1'b1, 32'h4433_2211);
    beat4(1'b1, 32'h8877_6655);
    beat4(1'b1, 32'h0000_A5A5);
    idle(4);
    n_cmp += 3;
    if (ecc4_n !== 1) begin n_bad++; $display("FAIL ecc_pulse got %0d exp 1", ecc4_n); end
    if (q4.size() !== 0) begin n_bad++; $display("FAIL ecc_no_payload got %0d exp 0", q4.size()); end
    if (len4 !== 16'd10) begin n_bad++; $display("FAIL ecc_meta_hold got %0d exp 10", len4); end
    send_wc8();
    n_cmp += 2;
    if (q4.size() !== 2) begin n_bad++; $display("FAIL ecc_recover_count got %0d exp 2", q4.size()); end
    if (len4 !== 16'd8 || ecc4_n !== 1) begin n_bad++; $display("FAIL ecc_recover_meta got len %0d ecc %0d exp 8 1", len4, ecc4_n); end
  endtask

  task automatic test_reject_skip();
    clear_logs();
    beat4(1'b1, 32'hB8B8_B8B8);
    beat4(1'b1, 32'h3500_082A);
    beat4(1'b1, 32'hB8B8_B8B8);
    beat4(1'b1, 32'h3200_082B);
    beat4(1'b1, 32'h0000_A5A5);
    idle(4);
    n_cmp += 3;
    if (q4.size() !== 0) begin n_bad++; $display("FAIL reject_no_output got %0d exp 0", q4.size()); end
    if (ecc4_n !== 0) begin n_bad++; $display("FAIL reject_ecc got %0d exp 0", ecc4_n); end
    if (len4 !== 16'd8 || type4 !== 6'h2B) begin n_bad++; $display("FAIL reject_meta_hold got len %0d type %h exp 8 2b", len4, type4); end
    send_wc10();
    n_cmp += 2;
    if (q4.size() !== 3) begin n_bad++; $display("FAIL reject_follow_count got %0d exp 3", q4.size()); end
    if (len4 !== 16'd10) begin n_bad++; $display("FAIL reject_follow_len got %0d exp 10", len4); end
  endtask

  task automatic test_abort_valid();
    clear_logs();
    beat4(1'b1, 32'hB8B8_B8B8);
    beat4(1'b1, 32'h2E00_0A2B);
    beat4(1'b1, 32'h1111_1111);
    beat4(1'b0, 32'h0000_0000);
    beat4(1'b1, 32'h2222_2222);
    beat4(1'b1, 32'h3333_3333);
    idle(4);
    n_cmp++;
    if (q4.size() !== 1) begin n_bad++; $display("FAIL abort_count got %0d exp 1", q4.size()); end
    if (q4.size() >= 1) begin
      n_cmp++;
      if (q4[0].data !== 32'h1111_1111 || q4[0].last !== 1'b0) begin n_bad++; $display("FAIL abort_beat got %h last %b exp 11111111 last 0", q4[0].data, q4[0].last); end
    end
    clear_logs();
    send_wc8();
    n_cmp++;
    if (q4.size() !== 2) begin n_bad++; $display("FAIL abort_recover got %0d exp 2", q4.size()); end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    beat4(1'b1, 32'hB8B8_B8B8);
    beat4(1'b1, 32'h2E00_0A2B);
    beat4(1'b1, 32'h1111_1111);
    beat4(1'b1, 32'h2222_2222);
    @(posedge clk);
    rst_n = 1'b0; dv4 = 1'b1; d4 = 32'h3333_3333;
    @(posedge clk);
    rst_n = 1'b1; dv4 = 1'b1; d4 = 32'h4444_4444;
    idle(4);
    n_cmp += 3;
    if (q4.size() !== 1) begin n_bad++; $display("FAIL rstmid_count got %0d exp 1", q4.size()); end
    if ({ov4, be4, last4} !== 6'h0) begin n_bad++; $display("FAIL rstmid_outputs got %b exp 000000", {ov4, be4, last4}); end
    if (len4 !== 16'd0 || type4 !== 6'h0) begin n_bad++; $display("FAIL rstmid_meta got len %0d type %h exp 0 0", len4, type4); end
    clear_logs();
    send_wc8();
    n_cmp += 2;
    if (q4.size() !== 2) begin n_bad++; $display("FAIL rstmid_recover got %0d exp 2", q4.size()); end
    if (len4 !== 16'd8) begin n_bad++; $display("FAIL rstmid_recover_len got %0d exp 8", len4); end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    dv4 = 1'b0; d4 = '0; dv2 = 1'b0; d2 = '0;
    rst_n = 1'b0;
    clear_logs();
    test_reset();
    test_basic();
    test_partial_beat();
    test_short_lanes2();
    test_odd_lanes2();
    test_ecc_error();
    test_reject_skip();
    test_abort_valid();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mipi_csi_packet_decoder_ml.md
Name: mipi_csi_packet_decoder_ml

Overview:
Parametrised CSI-2 packet decoder for 1, 2 or 4 aligned lanes.
- Consumes lane-aligned beats from the lane aligner in the byte-clock domain.
- Locates the sync beat, assembles and ECC-checks the packet header, and filters packets by data type and virtual channel.
- Strips header and CRC footer and emits payload beats with per-byte enables and a last-beat flag.
- Raises frame start/end pulses and an ECC-error pulse.

Parameters:
LANES, 4, lane count; legal values 1, 2, 4.
RAW_TYPE_MASK, 8'b0011_1000, bit i enables data type 0x28+i (default accepts 0x2B, 0x2C, 0x2D).
VC_MASK, 4'hF, bit v enables virtual channel v.

Ports:
clk_i  in  1  byte clock; all registers update on the falling edge.
reset_n_i  in  1  synchronous, active-low reset.
data_valid_i  in  1  input beat valid.
data_i  in  8*LANES  aligned bytes; byte k is lane k.
output_valid_o  out  1  payload beat valid.
data_o  out  8*LANES  payload bytes in received order.
byte_en_o  out  LANES  valid bytes of the current beat.
last_o  out  1  final payload beat of the packet.
packet_length_o  out  16  word count of the current packet.
packet_type_o  out  6  data type (DI[5:0]).
virtual_channel_o  out  2  DI[7:6].
frame_start_o  out  1  one-cycle pulse on an accepted FS short packet (DT 0x00).
frame_end_o  out  1  one-cycle pulse on an accepted FE short packet (DT 0x01).
ecc_error_o  out  1  one-cycle pulse on a header ECC mismatch.

Behaviour:
- Reset (reset_n_i=0 at an active edge): every output goes to 0, the FSM goes to IDLE, and the counters clear. Reset wins over all other events, including mid-payload.
- Input stage: data_i and data_valid_i are registered once. Decode then drives the output registers, so a beat sampled at edge k appears on the outputs after edge k+1. Pulses follow the same latency, referenced to the last header beat.
- FSM states: IDLE, HDR, PAYLOAD, SKIP.
- IDLE → HDR: when a valid beat has byte0 == 0xB8.
- HDR: collects 4 header bytes from 4/LANES consecutive valid beats, lane 0 first. Byte order is DI, WC_L, WC_H, ECC.
- ECC check: ECC[5:0] is compared with the CSI-2 Hamming parity of {WC_H, WC_L, DI}, where D0 = DI[0]. ECC[7:6] is ignored.
  - On mismatch: pulse ecc_error_o, return to IDLE, no other outputs change.
- Short packet (DT < 0x10): return to IDLE.
  - DT 0x00 with VC enabled: pulse frame_start_o.
  - DT 0x01 with VC enabled: pulse frame_end_o.
  - Other short types are ignored.
- Long packet, accepted (RAW_TYPE_MASK and VC_MASK both match):
  - Latch packet_length_o, packet_type_o and virtual_channel_o.
  - remaining = WC. Go to PAYLOAD, or to IDLE if WC == 0.
- Long packet, rejected: remaining = WC. Go to SKIP, or to IDLE if WC == 0.
  - SKIP counts identically but emits nothing, so payload bytes equal to 0xB8 are never taken as sync.
- PAYLOAD, per valid beat:
  - output_valid_o = 1.
  - byte_en_o = all ones if remaining >= LANES, else (1<<remaining) − 1.
  - last_o = (remaining <= LANES).
  - remaining decrements by min(remaining, LANES); at 0 go to IDLE.
  - The 2 CRC bytes are not checked. They fall into the post-payload beat, which IDLE discards unless byte0 == 0xB8.
- Invalid input: data_valid_i = 0 in HDR, PAYLOAD or SKIP aborts to IDLE. last_o is not asserted for an aborted packet.
- Metadata hold: packet_length_o, packet_type_o and virtual_channel_o hold until the next accepted long header; they clear only on reset.
- Idle outputs: output_valid_o, byte_en_o and last_o are 0 whenever no payload beat is output.
- Width rules: remaining is 16 bits and never wraps below 0.

Decomposition:
- Package mipi_csi_pkg holds:
  - SYNC_BYTE = 0xB8.
  - Data-type constants: DT_FS = 0x00, DT_FE = 0x01, DT_RAW6..DT_RAW14 = 0x28..0x2D.
  - The FSM state enum.
  - Function csi_header_ecc(24-bit) → 6-bit.
- Sub-module mipi_csi_header_ecc: combinational ECC generator plus comparator, outputs ecc_ok. Reusable by the TX packer.

Test Plan:
1. LANES=4: sync beat B8B8B8B8, then header bytes 2B,08,00,32, then 2 payload beats, then a CRC beat. Expect 2 output beats with byte_en 4'hF, last_o on beat 2, packet_length_o = 8, type 0x2B, output 2 cycles after input.
2. LANES=4, WC = 10: expect 3 beats with byte_en F, F, 3; last_o on the third.
3. LANES=2: header 00,00,00,00 (FS, ECC 0x00) → single frame_start_o pulse. Then header 01,00,00,07 (FE) → single frame_end_o pulse. No output_valid_o.
4. Header as in test 1 with ECC 0x33 → ecc_error_o pulse, no payload. The next good packet decodes normally.
5. Rejected type 0x2A with WC = 8 and payload containing 0xB8 in byte0 → no output and no false header. The following 0x2B packet is accepted.
6. data_valid_i dropped mid-payload, and separately reset_n_i = 0 mid-payload → outputs return to 0 and the FSM goes to IDLE. A subsequent packet decodes correctly.
